// File: rtl/txn_score_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | txn_score_pkg                                                         |
// | Encodings, thresholds, weights and sub-score helpers for the scorer.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package txn_score_pkg;

   localparam logic [1:0] c_meth_tether = 2'b00;
   localparam logic [1:0] c_meth_monero = 2'b01;
   localparam logic [1:0] c_meth_other  = 2'b10;

   localparam logic [63:0] c_val_th4 = 64'd400000;
   localparam logic [63:0] c_val_th3 = 64'd200000;
   localparam logic [63:0] c_val_th2 = 64'd100000;
   localparam logic [63:0] c_val_th1 = 64'd50000;
   localparam logic [63:0] c_val_th0 = 64'd10000;

   localparam logic [63:0] c_per_th4 = 64'd3600;
   localparam logic [63:0] c_per_th3 = 64'd1800;
   localparam logic [63:0] c_per_th2 = 64'd720;
   localparam logic [63:0] c_per_th1 = 64'd60;
   localparam logic [63:0] c_per_th0 = 64'd1;

   localparam logic [6:0] c_w_m_hi  = 7'd15;
   localparam logic [6:0] c_w_m_mid = 7'd10;
   localparam logic [6:0] c_w_m_lo  = 7'd5;
   localparam logic [6:0] c_w_i_max = 7'd35;
   localparam logic [6:0] c_w_v_max = 7'd20;
   localparam logic [6:0] c_w_p_max = 7'd30;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DIV   = 2'd1,
      ST_SCORE = 2'd2,
      ST_OUT   = 2'd3
   } state_e;

   function automatic logic [6:0] method_score(input logic crypto, input logic [6:0] oth_pct);
      if (crypto || oth_pct >= 7'd15) return c_w_m_hi;
      if (oth_pct >= 7'd10)           return c_w_m_mid;
      if (oth_pct >= 7'd5)            return c_w_m_lo;
      return 7'd0;
   endfunction

   // Ratio is symmetric: strongly one-directional flow scores high either way.
   function automatic logic [6:0] ratio_score(input logic [6:0] pct);
      if (pct >= 7'd95 || pct <= 7'd5)  return c_w_i_max;
      if (pct >= 7'd90 || pct <= 7'd10) return 7'd30;
      if (pct >= 7'd85 || pct <= 7'd15) return 7'd25;
      if (pct >= 7'd80 || pct <= 7'd20) return 7'd20;
      if (pct >= 7'd75 || pct <= 7'd25) return 7'd15;
      if (pct >= 7'd70 || pct <= 7'd30) return 7'd10;
      return 7'd0;
   endfunction

   function automatic logic [6:0] value_score(input logic [63:0] avg_v);
      if (avg_v >= c_val_th4) return c_w_v_max;
      if (avg_v >= c_val_th3) return 7'd17;
      if (avg_v >= c_val_th2) return 7'd14;
      if (avg_v >= c_val_th1) return 7'd10;
      if (avg_v >= c_val_th0) return 7'd7;
      return 7'd0;
   endfunction

   function automatic logic [6:0] period_score(input logic [63:0] avg_p);
      if (avg_p >= c_per_th4) return c_w_p_max;
      if (avg_p >= c_per_th3) return 7'd25;
      if (avg_p >= c_per_th2) return 7'd20;
      if (avg_p >= c_per_th1) return 7'd15;
      if (avg_p >= c_per_th0) return 7'd5;
      return 7'd0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | seq_divider                                                           |
// | Restoring unsigned divider, one quotient bit per cycle.               |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module seq_divider #(
   parameter int DIV_W = 31
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [DIV_W-1:0] dividend_i,
   input  logic [DIV_W-1:0] divisor_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [DIV_W-1:0] quotient_o
);
   localparam int CW = $clog2(DIV_W + 1);

   logic [DIV_W-1:0] rem_q, quo_q, dvsr_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q, done_q;
   logic [DIV_W:0]   w_trial;
   logic [DIV_W-1:0] w_diff;
   logic             w_ge;

   // Dividend bits shift out of the quotient register's top as quotient bits enter below.
   assign w_trial = {rem_q, quo_q[DIV_W-1]};
   assign w_ge    = w_trial >= {1'b0, dvsr_q};
   assign w_diff  = w_trial[DIV_W-1:0] - dvsr_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem_q  <= '0;
         quo_q  <= '0;
         dvsr_q <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (start_i && !busy_q) begin
            rem_q  <= '0;
            quo_q  <= dividend_i;
            dvsr_q <= divisor_i;
            cnt_q  <= CW'(DIV_W);
            busy_q <= 1'b1;
         end else if (busy_q) begin
            rem_q <= w_ge ? w_diff : w_trial[DIV_W-1:0];
            quo_q <= {quo_q[DIV_W-2:0], w_ge};
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end
      end
   end

   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign quotient_o = quo_q;

endmodule
`default_nettype wire

// File: rtl/txn_confidence_scorer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | txn_confidence_scorer                                                 |
// | Per-wallet transaction statistics and 0-100 confidence scoring.       |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module txn_confidence_scorer
   import txn_score_pkg::*;
#(
   parameter  int NUM_WALLETS = 4,
   parameter  int COUNT_W     = 10,
   parameter  int VALUE_W     = 20,
   parameter  int TS_W        = 31,
   parameter  int SUM_W       = 30,
   localparam int WID_W       = (NUM_WALLETS > 1) ? $clog2(NUM_WALLETS) : 1
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               txn_valid,
   output logic               txn_ready,
   input  logic [WID_W-1:0]   txn_wallet,
   input  logic [TS_W-1:0]    txn_time,
   input  logic               txn_in,
   input  logic [1:0]         txn_method,
   input  logic [VALUE_W-1:0] txn_value,
   input  logic               txn_last,
   output logic               score_valid,
   input  logic               score_ready,
   output logic [WID_W-1:0]   score_wallet,
   output logic [6:0]         score_m,
   output logic [6:0]         score_i,
   output logic [6:0]         score_v,
   output logic [6:0]         score_p,
   output logic [6:0]         confidence_score
);
   localparam int DIV_A = (SUM_W > TS_W) ? SUM_W : TS_W;
   localparam int DIV_W = (DIV_A > COUNT_W + 7) ? DIV_A : COUNT_W + 7;
   localparam logic [WID_W:0] c_num_wal = (WID_W+1)'(NUM_WALLETS);

   state_e state_q, state_d;

   logic [COUNT_W-1:0] tot_q   [NUM_WALLETS];
   logic [COUNT_W-1:0] in_q    [NUM_WALLETS];
   logic [COUNT_W-1:0] oth_q   [NUM_WALLETS];
   logic               cry_q   [NUM_WALLETS];
   logic [SUM_W-1:0]   sum_q   [NUM_WALLETS];
   logic [TS_W-1:0]    first_q [NUM_WALLETS];
   logic [TS_W-1:0]    last_q  [NUM_WALLETS];

   logic [WID_W-1:0] wid_q;
   logic [1:0]       idx_q;
   logic             launch_q;
   logic [6:0]       in_pct_q, oth_pct_q;
   logic [SUM_W-1:0] avg_v_q;
   logic [6:0]       sm_q, si_q, sv_q, sp_q, conf_q;

   logic             w_wal_ok, w_start, div_busy, div_done;
   logic [SUM_W:0]   w_sum_ext;
   logic [1:0]       w_sel;
   logic [TS_W-1:0]  w_span;
   logic [DIV_W-1:0] w_dvd, w_dvs, div_quo;
   logic [6:0]       w_m, w_i, w_v, w_p;

   assign txn_ready = (state_q == ST_IDLE) && !rst;
   assign w_wal_ok  = {1'b0, txn_wallet} < c_num_wal;
   assign w_sum_ext = {1'b0, sum_q[txn_wallet]} + (SUM_W+1)'(txn_value);

   // Next divide is issued on the same edge the previous quotient is captured.
   assign w_start = (launch_q || (div_done && idx_q != 2'd3)) && !div_busy;
   assign w_sel   = launch_q ? 2'd0 : idx_q + 2'd1;
   assign w_span  = last_q[wid_q] - first_q[wid_q];
   assign w_dvs   = DIV_W'(tot_q[wid_q]);

   always_comb begin
      w_dvd = '0;
      case (w_sel)
         2'd0:    w_dvd = DIV_W'(in_q[wid_q]) * DIV_W'(100);
         2'd1:    w_dvd = DIV_W'(oth_q[wid_q]) * DIV_W'(100);
         2'd2:    w_dvd = DIV_W'(sum_q[wid_q]);
         default: w_dvd = DIV_W'(w_span);
      endcase
   end

   seq_divider #(.DIV_W(DIV_W)) u_div (
      .clk        (clk),
      .rst        (rst),
      .start_i    (w_start),
      .dividend_i (w_dvd),
      .divisor_i  (w_dvs),
      .busy_o     (div_busy),
      .done_o     (div_done),
      .quotient_o (div_quo)
   );

   // The period quotient is still held by the divider during SCORE.
   assign w_m = method_score(cry_q[wid_q], oth_pct_q);
   assign w_i = ratio_score(in_pct_q);
   assign w_v = value_score(64'(avg_v_q));
   assign w_p = period_score(64'(div_quo));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (txn_valid && w_wal_ok && txn_last) state_d = ST_DIV;
         ST_DIV:   if (div_done && idx_q == 2'd3) state_d = ST_SCORE;
         ST_SCORE: state_d = ST_OUT;
         ST_OUT:   if (score_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_WALLETS; k++) begin
            tot_q[k]   <= '0;
            in_q[k]    <= '0;
            oth_q[k]   <= '0;
            cry_q[k]   <= 1'b0;
            sum_q[k]   <= '0;
            first_q[k] <= '0;
            last_q[k]  <= '0;
         end
         wid_q     <= '0;
         idx_q     <= '0;
         launch_q  <= 1'b0;
         in_pct_q  <= '0;
         oth_pct_q <= '0;
         avg_v_q   <= '0;
         sm_q      <= '0;
         si_q      <= '0;
         sv_q      <= '0;
         sp_q      <= '0;
         conf_q    <= '0;
      end else begin
         launch_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (txn_valid && w_wal_ok) begin
               if (tot_q[txn_wallet] == '0) first_q[txn_wallet] <= txn_time;
               last_q[txn_wallet] <= txn_time;
               if (tot_q[txn_wallet] != '1) tot_q[txn_wallet] <= tot_q[txn_wallet] + 1'b1;
               if (txn_in && in_q[txn_wallet] != '1) in_q[txn_wallet] <= in_q[txn_wallet] + 1'b1;
               if (txn_method == c_meth_other && oth_q[txn_wallet] != '1)
                  oth_q[txn_wallet] <= oth_q[txn_wallet] + 1'b1;
               if (txn_method == c_meth_tether || txn_method == c_meth_monero)
                  cry_q[txn_wallet] <= 1'b1;
               sum_q[txn_wallet] <= w_sum_ext[SUM_W] ? '1 : w_sum_ext[SUM_W-1:0];
               if (txn_last) begin
                  wid_q    <= txn_wallet;
                  idx_q    <= 2'd0;
                  launch_q <= 1'b1;
               end
            end
            ST_DIV: if (div_done) begin
               idx_q <= idx_q + 2'd1;
               case (idx_q)
                  2'd0:    in_pct_q  <= div_quo[6:0];
                  2'd1:    oth_pct_q <= div_quo[6:0];
                  2'd2:    avg_v_q   <= div_quo[SUM_W-1:0];
                  default: ;
               endcase
            end
            ST_SCORE: begin
               sm_q   <= w_m;
               si_q   <= w_i;
               sv_q   <= w_v;
               sp_q   <= w_p;
               conf_q <= w_m + w_i + w_v + w_p;
            end
            default: if (score_ready) begin
               tot_q[wid_q]   <= '0;
               in_q[wid_q]    <= '0;
               oth_q[wid_q]   <= '0;
               cry_q[wid_q]   <= 1'b0;
               sum_q[wid_q]   <= '0;
               first_q[wid_q] <= '0;
               last_q[wid_q]  <= '0;
               sm_q           <= '0;
               si_q           <= '0;
               sv_q           <= '0;
               sp_q           <= '0;
               conf_q         <= '0;
            end
         endcase
      end
   end

   assign score_valid      = (state_q == ST_OUT);
   assign score_wallet     = wid_q;
   assign score_m          = sm_q;
   assign score_i          = si_q;
   assign score_v          = sv_q;
   assign score_p          = sp_q;
   assign confidence_score = conf_q;

endmodule
`default_nettype wire

// File: tb/tb_txn_confidence_scorer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_txn_confidence_scorer                                              |
// | Directed and randomized checks against a behavioural scoring model.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_txn_confidence_scorer;
   localparam int  c_div_w = 31;
   localparam int  c_lat   = 4 * (c_div_w + 1) + 2;
   localparam longint c_ts_mask = 64'h7FFF_FFFF;

   logic        clk = 1'b0;
   logic        rst;
   logic        txn_valid, txn_ready, txn_in, txn_last;
   logic [1:0]  txn_wallet, txn_method;
   logic [30:0] txn_time;
   logic [19:0] txn_value;
   logic        score_valid, score_ready;
   logic [1:0]  score_wallet;
   logic [6:0]  score_m, score_i, score_v, score_p, confidence_score;

   int n_chk  = 0;
   int n_fail = 0;

   longint m_tot[4], m_in[4], m_oth[4], m_sum[4], m_first[4], m_last[4];
   bit     m_cry[4];
   int     obs_m, obs_i, obs_v, obs_p, obs_c;

   always #5 clk = ~clk;

   txn_confidence_scorer dut (
      .clk(clk), .rst(rst),
      .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_wallet(txn_wallet),
      .txn_time(txn_time), .txn_in(txn_in), .txn_method(txn_method),
      .txn_value(txn_value), .txn_last(txn_last),
      .score_valid(score_valid), .score_ready(score_ready), .score_wallet(score_wallet),
      .score_m(score_m), .score_i(score_i), .score_v(score_v), .score_p(score_p),
      .confidence_score(confidence_score)
   );

   task automatic check_eq(input string tag, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic void model_clear(input int w);
      m_tot[w] = 0; m_in[w] = 0; m_oth[w] = 0; m_sum[w] = 0;
      m_first[w] = 0; m_last[w] = 0; m_cry[w] = 0;
   endfunction

   function automatic void model_accept(input int w, input int inb, input int meth,
                                        input longint val, input longint t);
      if (m_tot[w] == 0) m_first[w] = t;
      m_last[w] = t;
      m_tot[w]  = (m_tot[w] + 1 > 1023) ? 1023 : m_tot[w] + 1;
      m_in[w]   = (m_in[w] + inb > 1023) ? 1023 : m_in[w] + inb;
      if (meth == 2) m_oth[w] = (m_oth[w] + 1 > 1023) ? 1023 : m_oth[w] + 1;
      if (meth <= 1) m_cry[w] = 1;
      m_sum[w] = (m_sum[w] + val > (64'd1 << 30) - 1) ? (64'd1 << 30) - 1 : m_sum[w] + val;
   endfunction

   function automatic void model_expect(input int w, output int em, output int ei,
                                        output int ev, output int ep);
      longint ip, op, av, ap;
      ip = m_in[w] * 100 / m_tot[w];
      op = m_oth[w] * 100 / m_tot[w];
      av = m_sum[w] / m_tot[w];
      ap = ((m_last[w] - m_first[w]) & c_ts_mask) / m_tot[w];
      em = (m_cry[w] || op >= 15) ? 15 : (op >= 10) ? 10 : (op >= 5) ? 5 : 0;
      if      (ip >= 95 || ip <= 5)  ei = 35;
      else if (ip >= 90 || ip <= 10) ei = 30;
      else if (ip >= 85 || ip <= 15) ei = 25;
      else if (ip >= 80 || ip <= 20) ei = 20;
      else if (ip >= 75 || ip <= 25) ei = 15;
      else if (ip >= 70 || ip <= 30) ei = 10;
      else                           ei = 0;
      ev = (av >= 400000) ? 20 : (av >= 200000) ? 17 : (av >= 100000) ? 14 :
           (av >= 50000) ? 10 : (av >= 10000) ? 7 : 0;
      ep = (ap >= 3600) ? 30 : (ap >= 1800) ? 25 : (ap >= 720) ? 20 :
           (ap >= 60) ? 15 : (ap >= 1) ? 5 : 0;
   endfunction

   task automatic send(input int w, input int inb, input int meth, input longint val,
                       input longint t, input int last);
      int waited = 0;
      txn_wallet = 2'(w); txn_in = inb[0]; txn_method = 2'(meth);
      txn_value = 20'(val); txn_time = 31'(t); txn_last = last[0];
      txn_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (txn_ready) break;
         waited++;
         if (waited > 2000) begin
            check_eq("send_timeout", 0, 1);
            txn_valid = 1'b0;
            return;
         end
      end
      @(posedge clk); #1;
      txn_valid = 1'b0;
      model_accept(w, inb, meth, val, t & c_ts_mask);
   endtask

   // Called one step after the closing handshake edge.
   task automatic get_result(input int w, input int hold);
      int cyc = 0;
      int em, ei, ev, ep;
      model_expect(w, em, ei, ev, ep);
      while (!score_valid && cyc < 1000) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_eq("latency", cyc, c_lat);
      check_eq("score_wallet", score_wallet, w);
      check_eq("score_m", score_m, em);
      check_eq("score_i", score_i, ei);
      check_eq("score_v", score_v, ev);
      check_eq("score_p", score_p, ep);
      check_eq("confidence", confidence_score, em + ei + ev + ep);
      obs_m = score_m; obs_i = score_i; obs_v = score_v; obs_p = score_p;
      obs_c = confidence_score;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check_eq("hold_valid", score_valid, 1);
         check_eq("hold_conf", confidence_score, obs_c);
         check_eq("hold_txn_ready", txn_ready, 0);
      end
      score_ready = 1'b1;
      @(posedge clk); #1;
      score_ready = 1'b0;
      model_clear(w);
      check_eq("valid_after_hs", score_valid, 0);
      check_eq("ready_after_hs", txn_ready, 1);
   endtask

   initial begin
      longint tm;
      int     w, lst, rise;
      rst = 1'b1; txn_valid = 1'b0; txn_wallet = '0; txn_time = '0; txn_in = 1'b0;
      txn_method = '0; txn_value = '0; txn_last = 1'b0; score_ready = 1'b0;
      for (int k = 0; k < 4; k++) model_clear(k);

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_txn_ready", txn_ready, 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check_eq("post_rst_ready", txn_ready, 1);
      check_eq("post_rst_valid", score_valid, 0);
      check_eq("post_rst_conf", confidence_score, 0);
      check_eq("post_rst_wallet", score_wallet, 0);

      // Wallet 0, all inbound "other"; a pending transaction is held during the result.
      for (int k = 0; k < 4; k++) send(0, 1, 2, 20000, k * 100, (k == 3) ? 1 : 0);
      txn_wallet = 2'd0; txn_in = 1'b0; txn_method = 2'd3; txn_value = '0;
      txn_time = 31'd5; txn_last = 1'b1; txn_valid = 1'b1;
      get_result(0, 20);
      check_eq("tp1_conf", obs_c, 72);
      @(posedge clk); #1;
      txn_valid = 1'b0;
      model_accept(0, 0, 3, 0, 5);
      get_result(0, 0);
      check_eq("pending_conf", obs_c, 35);

      // Wallet 2: half inbound, crypto present, large steady values.
      for (int k = 0; k < 10; k++)
         send(2, (k < 5) ? 1 : 0, (k == 0) ? 2 : 0, 400000, k * 4000, (k == 9) ? 1 : 0);
      get_result(2, 0);
      check_eq("tp2_m", obs_m, 15);
      check_eq("tp2_i", obs_i, 0);
      check_eq("tp2_v", obs_v, 20);
      check_eq("tp2_p", obs_p, 30);
      check_eq("tp2_conf", obs_c, 65);

      // Interleaved wallets 1 and 3.
      send(1, 1, 0, 50000, 1000, 0);
      send(3, 0, 2, 120000, 1010, 0);
      send(1, 0, 2, 7000, 1500, 0);
      send(3, 1, 2, 90000, 4000, 1);
      get_result(3, 2);
      send(1, 1, 1, 300000, 9000, 1);
      get_result(1, 0);
      send(3, 0, 3, 0, 10, 1);
      get_result(3, 0);
      check_eq("w3_cleared_conf", obs_c, 35);

      // Reset during the divide phase aborts the window.
      send(1, 1, 2, 99999, 100, 0);
      send(1, 1, 2, 99999, 90000, 1);
      repeat (50) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      #1;
      check_eq("mid_rst_ready", txn_ready, 0);
      check_eq("mid_rst_valid", score_valid, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) model_clear(k);
      rise = 0;
      repeat (200) begin
         @(posedge clk); #1;
         if (score_valid) rise = 1;
      end
      check_eq("no_result_after_rst", rise, 0);
      send(1, 0, 3, 0, 777, 1);
      get_result(1, 0);
      check_eq("after_rst_conf", obs_c, 35);
      check_eq("after_rst_p", obs_p, 0);

      // Timestamp wrap across 2^31.
      send(2, 1, 3, 0, (64'd1 << 31) - 10, 0);
      send(2, 0, 3, 0, 50, 1);
      get_result(2, 0);
      check_eq("wrap_p", obs_p, 5);

      // Randomized traffic across all wallets.
      tm = 0;
      for (int k = 0; k < 160; k++) begin
         w   = $urandom_range(0, 3);
         lst = ($urandom_range(0, 5) == 0) ? 1 : 0;
         tm  = tm + $urandom_range(0, 3000);
         send(w, $urandom_range(0, 1), $urandom_range(0, 3),
              longint'($urandom_range(0, (1 << 20) - 1)), tm, lst);
         if (lst != 0) get_result(w, $urandom_range(0, 3));
      end
      for (int k = 0; k < 4; k++) begin
         send(k, 1, 1, 1234, tm + 5000, 1);
         get_result(k, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
